// File: rtl/nios_spi_rx_fifo_port.sv
// Avalon-MM slave that buffers SPI receive words in a FIFO for the Nios II CPU.
// Provides DATA/STATUS/CONTROL/THRESHOLD registers, sticky overflow and a level interrupt.
module nios_spi_rx_fifo_port #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  input  logic                  in_valid,
  output logic                  irq
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d, thr_q, thr_d;
  logic                  ovf_q, ovf_d, data_ie_q, data_ie_d, ovf_ie_q, ovf_ie_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q, irq_d;

  logic rd_en_s, wr_en_s, empty_s, full_s, thr_hit_s, thr_hit_d_s;
  logic pop_ok_s, push_ok_s, ovf_set_s, ovf_clr_s, flush_s;
  logic [31:0] head_s, status_s;

  assign rd_en_s   = chipselect & read;
  assign wr_en_s   = chipselect & write;
  assign empty_s   = (level_q == LW'(0));
  assign full_s    = (level_q == LW'(DEPTH));
  assign thr_hit_s = (thr_q != LW'(0)) && (level_q >= thr_q);

  assign flush_s   = wr_en_s & (address == 2'd2) & writedata[2];
  assign ovf_clr_s = wr_en_s & (address == 2'd1) & writedata[2];
  assign pop_ok_s  = rd_en_s & (address == 2'd0) & ~empty_s;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push_ok_s = in_valid & (~full_s | pop_ok_s);
  assign ovf_set_s = in_valid & full_s & ~pop_ok_s;

  // Read-data formatting for the head word and the status register.
  always_comb begin
    head_s   = 32'd0;
    status_s = 32'd0;
    if (!empty_s) begin
      head_s[DATA_WIDTH-1:0] = mem_q[rd_ptr_q];
    end else begin
      head_s = 32'd0;
    end
    status_s[0]       = empty_s;
    status_s[1]       = full_s;
    status_s[2]       = ovf_q;
    status_s[3]       = thr_hit_s;
    status_s[8 +: LW] = level_q;
  end

  // Next-state for pointers, level, control registers, read data and interrupt.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    thr_d      = thr_q;
    data_ie_d  = data_ie_q;
    ovf_ie_d   = ovf_ie_q;
    readdata_d = 32'd0;

    if (flush_s) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      level_d  = LW'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      level_d = level_q + LW'(push_ok_s) - LW'(pop_ok_s);
    end

    // Set beats clear when both land on the same edge.
    ovf_d = ovf_set_s | (ovf_q & ~ovf_clr_s);

    if (wr_en_s && address == 2'd2) begin
      data_ie_d = writedata[0];
      ovf_ie_d  = writedata[1];
    end else begin
      data_ie_d = data_ie_q;
      ovf_ie_d  = ovf_ie_q;
    end

    if (wr_en_s && address == 2'd3) begin
      thr_d = writedata[LW-1:0];
    end else begin
      thr_d = thr_q;
    end

    if (rd_en_s) begin
      case (address)
        2'd0:    readdata_d = head_s;
        2'd1:    readdata_d = status_s;
        2'd2:    readdata_d = {30'd0, ovf_ie_q, data_ie_q};
        2'd3:    readdata_d = {{(32-LW){1'b0}}, thr_q};
        default: readdata_d = 32'd0;
      endcase
    end else begin
      readdata_d = 32'd0;
    end

    thr_hit_d_s = (thr_d != LW'(0)) && (level_d >= thr_d);
    irq_d       = (data_ie_d & thr_hit_d_s) | (ovf_ie_d & ovf_d);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      level_q    <= LW'(0);
      thr_q      <= LW'(1);
      ovf_q      <= 1'b0;
      data_ie_q  <= 1'b0;
      ovf_ie_q   <= 1'b0;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      thr_q      <= thr_d;
      ovf_q      <= ovf_d;
      data_ie_q  <= data_ie_d;
      ovf_ie_q   <= ovf_ie_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush_s) begin
      mem_q[wr_ptr_q] <= in_port;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_spi_rx_fifo_port.sv
// Directed bench for nios_spi_rx_fifo_port (DATA_WIDTH=16, DEPTH=16) with a read-data scoreboard.
module tb_nios_spi_rx_fifo_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] in_port = 16'd0;
  logic        in_valid = 1'b0;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  nios_spi_rx_fifo_port #(.DATA_WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .in_valid(in_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st(input bit e, input bit f, input bit o, input bit t, input int lvl);
    st = ({24'd0, 8'(lvl)} << 8) | {28'd0, t, o, f, e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_rd();
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, readdata, e);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    chipselect = 1'b1; read = 1'b1; address = a;
    cycle();
    chipselect = 1'b0; read = 1'b0;
    check_rd();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    cycle();
    chipselect = 1'b0; write = 1'b0; writedata = 32'd0;
  endtask

  task automatic push(input logic [15:0] w);
    in_valid = 1'b1; in_port = w;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) cycle();
    reset_n = 1'b1;
    cycle();

    // Reset values
    rd(2'd1, 32'h1, "rst_status");
    rd(2'd0, 32'h0, "rst_data");
    rd(2'd2, 32'h0, "rst_control");
    rd(2'd3, 32'h1, "rst_threshold");

    // Basic push / pop
    push(16'hA5A5); push(16'h1234); push(16'hFFFF);
    rd(2'd1, st(0, 0, 0, 1, 3), "status_lvl3");
    rd(2'd0, 32'h0000A5A5, "data0");
    rd(2'd0, 32'h00001234, "data1");
    rd(2'd0, 32'h0000FFFF, "data2");
    rd(2'd1, st(1, 0, 0, 0, 0), "status_empty");
    rd(2'd0, 32'h0, "data_empty");

    // Overflow
    for (int i = 0; i < 17; i++) push(16'(i));
    rd(2'd1, st(0, 1, 1, 1, 16), "status_ovf_full");
    for (int i = 0; i < 16; i++) rd(2'd0, 32'(i), "ovf_drain");
    rd(2'd1, st(1, 0, 1, 0, 0), "status_ovf_empty");
    wr(2'd1, 32'h4);
    rd(2'd1, st(1, 0, 0, 0, 0), "status_ovf_clr");

    // Push and pop at full
    for (int i = 0; i < 16; i++) push(16'(100 + i));
    exp_q.push_back(32'd100); tag_q.push_back("full_pushpop");
    in_valid = 1'b1; in_port = 16'h0055;
    chipselect = 1'b1; read = 1'b1; address = 2'd0;
    cycle();
    in_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    check_rd();
    rd(2'd1, st(0, 1, 0, 1, 16), "status_full_noovf");
    for (int i = 1; i < 16; i++) rd(2'd0, 32'(100 + i), "full_drain");
    rd(2'd0, 32'h55, "full_last");

    // Push and pop when empty: push only, read returns 0
    exp_q.push_back(32'd0); tag_q.push_back("empty_pushpop");
    in_valid = 1'b1; in_port = 16'h0077;
    chipselect = 1'b1; read = 1'b1; address = 2'd0;
    cycle();
    in_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    check_rd();
    rd(2'd1, st(0, 0, 0, 1, 1), "status_empty_pushpop");
    rd(2'd0, 32'h77, "empty_pushpop_word");

    // Pointer wrap
    for (int i = 0; i < 20; i++) begin
      push(16'(16'h0300 + 16'(i)));
      rd(2'd0, 32'h300 + 32'(i), "wrap");
    end
    rd(2'd1, st(1, 0, 0, 0, 0), "status_wrap");

    // Threshold interrupt
    wr(2'd3, 32'd4);
    wr(2'd2, 32'h1);
    rd(2'd3, 32'd4, "thr_rb");
    rd(2'd2, 32'h1, "ctl_rb");
    push(16'h0A01); push(16'h0A02); push(16'h0A03);
    cycle();
    chk("irq_lvl3", 32'(irq), 32'd0);
    push(16'h0A04);
    cycle();
    chk("irq_lvl4", 32'(irq), 32'd1);
    rd(2'd0, 32'h0A01, "irq_pop");
    cycle();
    chk("irq_drop", 32'(irq), 32'd0);
    wr(2'd3, 32'd0);
    for (int i = 0; i < 13; i++) push(16'(i));
    cycle();
    chk("irq_thr0", 32'(irq), 32'd0);
    rd(2'd1, st(0, 1, 0, 0, 16), "status_thr0_full");

    // Flush with same-cycle push
    wr(2'd2, 32'h4);
    for (int i = 0; i < 5; i++) push(16'(i));
    rd(2'd1, st(0, 0, 0, 0, 5), "status_pre_flush");
    in_valid = 1'b1; in_port = 16'h0BAD;
    wr(2'd2, 32'h4);
    in_valid = 1'b0;
    rd(2'd1, st(1, 0, 0, 0, 0), "status_flush");
    rd(2'd2, 32'h0, "ctl_flush");
    rd(2'd0, 32'h0, "data_flush");

    // Overflow interrupt, flush keeps overflow
    wr(2'd2, 32'h2);
    for (int i = 0; i < 17; i++) push(16'(16'h0200 + 16'(i)));
    cycle();
    chk("irq_ovf", 32'(irq), 32'd1);
    wr(2'd2, 32'h6);
    rd(2'd1, st(1, 0, 1, 0, 0), "status_flush_ovf");
    chk("irq_ovf_flush", 32'(irq), 32'd1);
    wr(2'd1, 32'h4);
    cycle();
    chk("irq_ovf_clr", 32'(irq), 32'd0);

    // Overflow set and clear in the same cycle: set wins
    for (int i = 0; i < 16; i++) push(16'(16'h0400 + 16'(i)));
    in_valid = 1'b1; in_port = 16'h0EEE;
    wr(2'd1, 32'h4);
    in_valid = 1'b0;
    rd(2'd1, st(0, 1, 1, 0, 16), "status_setclr");
    cycle();
    chk("irq_setclr", 32'(irq), 32'd1);

    // Asynchronous reset mid-stream
    rd(2'd0, 32'h400, "pre_reset_data");
    reset_n = 1'b0;
    #2;
    chk("rst_async_readdata", readdata, 32'd0);
    chk("rst_async_irq", 32'(irq), 32'd0);
    cycle();
    reset_n = 1'b1;
    cycle();
    rd(2'd1, 32'h1, "post_rst_status");
    rd(2'd2, 32'h0, "post_rst_control");
    rd(2'd3, 32'h1, "post_rst_threshold");
    rd(2'd0, 32'h0, "post_rst_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
